// File: rtl/hazard_stall_controller_if.sv
// ID-stage hazard fields and pipeline-control outputs shared by the pipeline and the
// hazard/stall controller.
interface hazard_stall_controller_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_is_ecall;
  logic                  id_x17_is_10;
  logic                  ex_flush;

  logic                  pc_write;
  logic                  if_id_write;
  logic                  id_ex_bubble;
  logic                  if_id_flush;
  logic                  halted;
  logic [CNT_W-1:0]      stall_cycles;

  // Controller side
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
           id_mem_read, id_is_ecall, id_x17_is_10, ex_flush,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, halted, stall_cycles
  );

  // Pipeline side
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
           id_mem_read, id_is_ecall, id_x17_is_10, ex_flush,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, halted, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use stall, mispredict flush and ecall-halt drain control for a 5-stage pipeline.
// Tracks destination tags of the instructions in EX/MEM/WB.
module hazard_stall_controller #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  hazard_stall_controller_if.slave io_hz
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } tag_t;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalted
  } state_e;

  tag_t             r_ex, r_mem, r_wb;
  tag_t             w_id_tag, w_ex_d;
  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;

  logic w_rs1_hit, w_rs2_hit;
  logic w_load_use, w_halt_req, w_issue, w_cnt_inc, w_pipe_empty;
  logic w_pc_write, w_if_id_write, w_id_ex_bubble, w_if_id_flush;
  logic w_unused_tags;

  always_comb begin
    w_rs1_hit  = io_hz.id_use_rs1 && (io_hz.id_rs1 == r_ex.rd);
    w_rs2_hit  = io_hz.id_use_rs2 && (io_hz.id_rs2 == r_ex.rd);
    // Only a load still in EX is uncoverable; one cycle later forwarding from MEM works.
    w_load_use = io_hz.id_valid && r_ex.valid && r_ex.mem_read && (r_ex.rd != '0) &&
                 (w_rs1_hit || w_rs2_hit);
    w_halt_req = io_hz.id_valid && io_hz.id_is_ecall && io_hz.id_x17_is_10 && !w_load_use;
    // A halting ecall retires in ID; it never occupies a tag slot.
    w_issue    = (r_state == StRun) && io_hz.id_valid && !w_load_use && !io_hz.ex_flush &&
                 !w_halt_req;

    w_id_tag.valid     = 1'b1;
    w_id_tag.rd        = io_hz.id_rd;
    w_id_tag.reg_write = io_hz.id_reg_write;
    w_id_tag.mem_read  = io_hz.id_mem_read;
    w_ex_d             = w_issue ? w_id_tag : '0;

    w_pipe_empty = !r_ex.valid && !r_mem.valid && !r_wb.valid;
  end

  always_comb begin
    w_state_d      = r_state;
    w_pc_write     = 1'b1;
    w_if_id_write  = 1'b1;
    w_id_ex_bubble = 1'b0;
    w_if_id_flush  = 1'b0;
    w_cnt_inc      = 1'b0;
    unique case (r_state)
      StRun: begin
        if (io_hz.ex_flush) begin
          w_if_id_flush  = 1'b1;
          w_id_ex_bubble = 1'b1;
        end else if (w_load_use) begin
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b0;
          w_id_ex_bubble = 1'b1;
          w_cnt_inc      = 1'b1;
        end else if (w_halt_req) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        w_pc_write     = 1'b0;
        w_if_id_write  = 1'b0;
        w_id_ex_bubble = 1'b1;
        w_cnt_inc      = 1'b1;
        if (w_pipe_empty) begin
          w_state_d = StHalted;
        end
      end
      StHalted: begin
        w_pc_write     = 1'b0;
        w_if_id_write  = 1'b0;
        w_id_ex_bubble = 1'b1;
      end
      default: w_state_d = StRun;
    endcase
  end

  always_comb begin
    w_cnt_d = r_cnt;
    if (w_cnt_inc && (r_cnt != '1)) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_state <= StRun;
      r_cnt   <= '0;
    end else begin
      r_ex    <= w_ex_d;
      r_mem   <= r_ex;
      r_wb    <= r_mem;
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign io_hz.pc_write     = w_pc_write;
  assign io_hz.if_id_write  = w_if_id_write;
  assign io_hz.id_ex_bubble = w_id_ex_bubble;
  assign io_hz.if_id_flush  = w_if_id_flush;
  assign io_hz.halted       = (r_state == StHalted);
  assign io_hz.stall_cycles = r_cnt;

  // WB tag payload is kept for visibility alongside forwarding; only its valid bit matters here.
  assign w_unused_tags = ^{r_wb.rd, r_wb.reg_write, r_wb.mem_read};

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized + directed bench for hazard_stall_controller against an issue-history model.
module tb_hazard_stall_controller;

  localparam int unsigned RW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_stall_controller_if #(.REG_ADDR_W(RW), .CNT_W(32)) u_if ();
  hazard_stall_controller_if #(.REG_ADDR_W(RW), .CNT_W(2))  u_if2 ();

  assign u_if2.id_valid     = u_if.id_valid;
  assign u_if2.id_rs1       = u_if.id_rs1;
  assign u_if2.id_rs2       = u_if.id_rs2;
  assign u_if2.id_use_rs1   = u_if.id_use_rs1;
  assign u_if2.id_use_rs2   = u_if.id_use_rs2;
  assign u_if2.id_rd        = u_if.id_rd;
  assign u_if2.id_reg_write = u_if.id_reg_write;
  assign u_if2.id_mem_read  = u_if.id_mem_read;
  assign u_if2.id_is_ecall  = u_if.id_is_ecall;
  assign u_if2.id_x17_is_10 = u_if.id_x17_is_10;
  assign u_if2.ex_flush     = u_if.ex_flush;

  hazard_stall_controller #(.REG_ADDR_W(RW), .CNT_W(32)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_hz   (u_if.slave)
  );

  hazard_stall_controller #(.REG_ADDR_W(RW), .CNT_W(2)) u_dut_sat (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_hz   (u_if2.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: what was issued into EX during each of the last three cycles (0 = most recent).
  logic          h_v  [3];
  logic [RW-1:0] h_rd [3];
  logic          h_mr [3];
  int            mode;     // 0 running, 1 draining, 2 halted
  longint        cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_lu();
    return u_if.id_valid && h_v[0] && h_mr[0] && (h_rd[0] != 0) &&
           ((u_if.id_use_rs1 && u_if.id_rs1 == h_rd[0]) ||
            (u_if.id_use_rs2 && u_if.id_rs2 == h_rd[0]));
  endfunction

  task automatic set_id(input logic v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                        input logic u1, input logic u2, input logic [RW-1:0] rd,
                        input logic rw, input logic mr, input logic ec, input logic x17,
                        input logic fl);
    u_if.id_valid     = v;
    u_if.id_rs1       = rs1;
    u_if.id_rs2       = rs2;
    u_if.id_use_rs1   = u1;
    u_if.id_use_rs2   = u2;
    u_if.id_rd        = rd;
    u_if.id_reg_write = rw;
    u_if.id_mem_read  = mr;
    u_if.id_is_ecall  = ec;
    u_if.id_x17_is_10 = x17;
    u_if.ex_flush     = fl;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic compare();
    logic lu;
    logic e_pc, e_ifid, e_bub, e_fl;
    #1;
    lu = model_lu();
    if (mode == 0) begin
      if (u_if.ex_flush) {e_pc, e_ifid, e_bub, e_fl} = 4'b1111;
      else if (lu)       {e_pc, e_ifid, e_bub, e_fl} = 4'b0010;
      else               {e_pc, e_ifid, e_bub, e_fl} = 4'b1100;
    end else begin
      {e_pc, e_ifid, e_bub, e_fl} = 4'b0010;
    end
    chk("pc_write",     u_if.pc_write,      e_pc);
    chk("if_id_write",  u_if.if_id_write,   e_ifid);
    chk("id_ex_bubble", u_if.id_ex_bubble,  e_bub);
    chk("if_id_flush",  u_if.if_id_flush,   e_fl);
    chk("halted",       u_if.halted,        mode == 2);
    chk("stall_cycles", u_if.stall_cycles,  cnt);
    chk("stall_sat",    u_if2.stall_cycles, (cnt > 3) ? 3 : cnt);
  endtask

  task automatic advance();
    logic lu, halt, issue, empty, inc;
    lu    = model_lu();
    halt  = u_if.id_valid && u_if.id_is_ecall && u_if.id_x17_is_10 && !lu;
    issue = (mode == 0) && u_if.id_valid && !lu && !u_if.ex_flush && !halt;
    empty = !h_v[0] && !h_v[1] && !h_v[2];
    inc   = ((mode == 0) && lu && !u_if.ex_flush) || (mode == 1);
    @(posedge clk);
    if (inc && cnt < 64'hFFFF_FFFF) cnt++;
    if (mode == 0 && halt && !u_if.ex_flush) mode = 1;
    else if (mode == 1 && empty)             mode = 2;
    for (int i = 2; i > 0; i--) begin
      h_v[i]  = h_v[i-1];
      h_rd[i] = h_rd[i-1];
      h_mr[i] = h_mr[i-1];
    end
    h_v[0]  = issue;
    h_rd[0] = u_if.id_rd;
    h_mr[0] = u_if.id_mem_read;
    @(negedge clk);
  endtask

  task automatic step();
    compare();
    advance();
  endtask

  // Called at a falling edge; reset takes effect without waiting for a clock.
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_pc_write",    u_if.pc_write,     1);
    chk("rst_if_id_write", u_if.if_id_write,  1);
    chk("rst_bubble",      u_if.id_ex_bubble, 0);
    chk("rst_flush",       u_if.if_id_flush,  0);
    chk("rst_halted",      u_if.halted,       0);
    chk("rst_stall",       u_if.stall_cycles, 0);
    for (int i = 0; i < 3; i++) begin
      h_v[i] = 1'b0; h_rd[i] = '0; h_mr[i] = 1'b0;
    end
    mode = 0;
    cnt  = 0;
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    do_reset();

    // Load-use: exactly one stall cycle
    set_id(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0); step();
    set_id(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0); compare();
    chk("lu_pc_frozen", u_if.pc_write, 0);
    chk("lu_bubble", u_if.id_ex_bubble, 1);
    advance();
    compare();
    chk("lu_resume_pc", u_if.pc_write, 1);
    chk("lu_resume_bubble", u_if.id_ex_bubble, 0);
    chk("lu_count", u_if.stall_cycles, 1);
    advance();

    // x0 destination never stalls
    set_id(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0); step();
    set_id(1, 0, 0, 1, 1, 3, 1, 0, 0, 0, 0); compare();
    chk("x0_no_stall", u_if.pc_write, 1);
    chk("x0_count", u_if.stall_cycles, 1);
    advance();

    // Flush beats load-use
    set_id(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0); step();
    set_id(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 1); compare();
    chk("fl_flush", u_if.if_id_flush, 1);
    chk("fl_bubble", u_if.id_ex_bubble, 1);
    chk("fl_pc", u_if.pc_write, 1);
    advance();
    idle(); compare();
    chk("fl_count", u_if.stall_cycles, 1);
    advance();

    // Push count past the 2-bit counter's all-ones value
    for (int k = 0; k < 3; k++) begin
      set_id(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0); step();
      set_id(1, 0, 5, 0, 1, 6, 1, 0, 0, 0, 0); step();
      step();
    end
    idle(); compare();
    chk("sat_hold", u_if2.stall_cycles, 3);
    chk("sat_wide", u_if.stall_cycles, 4);
    advance();

    // Halting ecall with three valid older instructions
    for (int k = 0; k < 3; k++) begin
      set_id(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
    end
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); step();
    idle();
    for (int k = 0; k < 3; k++) begin
      compare();
      chk("drain_pc", u_if.pc_write, 0);
      chk("drain_not_halted", u_if.halted, 0);
      advance();
    end
    compare();
    chk("halted_set", u_if.halted, 1);
    chk("halt_count", u_if.stall_cycles, 7);
    advance();
    set_id(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 1); compare();
    chk("halted_held", u_if.halted, 1);
    chk("halted_count_frozen", u_if.stall_cycles, 7);
    advance();
    do_reset();

    // ecall without x17==10 is a NOP
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    idle();
    for (int k = 0; k < 4; k++) step();
    compare();
    chk("nop_ecall_halted", u_if.halted, 0);
    chk("nop_ecall_pc", u_if.pc_write, 1);
    advance();

    // Halting ecall killed by a coincident flush
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); compare();
    chk("ecall_flush", u_if.if_id_flush, 1);
    advance();
    idle();
    for (int k = 0; k < 4; k++) step();
    compare();
    chk("ecall_flush_run", u_if.pc_write, 1);
    chk("ecall_flush_halted", u_if.halted, 0);
    advance();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ((mode == 2 && $urandom_range(0, 7) == 0) ||
          (mode == 1 && $urandom_range(0, 19) == 0) ||
          $urandom_range(0, 499) == 0) begin
        do_reset();
      end
      set_id($urandom_range(0, 99) < 85,
             RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             RW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 4,
             1'($urandom_range(0, 1)), $urandom_range(0, 99) < 8);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
